// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Two-master arbiter and watchdog in front of the ROM/RAM/MMIO address decoder.
// Master 0 is the CPU and master 1 is a secondary master (DMA / debug loader).
// The bus is granted round-robin and held until the decoder completes the
// access. An access the decoder never answers is terminated after
// TIMEOUT_CYCLES busy cycles: the owner gets ready with rdata = 0 and
// timeout_error pulses for one cycle.
//
// Parameters
//   TIMEOUT_CYCLES : busy cycles without s_ready before forced termination (>= 2)
//   CNT_WIDTH      : width of the timeout counter, must be able to hold TIMEOUT_CYCLES
//
// Ports
//   clk, reset_n                 : clock, synchronous active-low reset
//   mX_valid/instr/addr/wdata/wstrb : master X request (held until mX_ready)
//   mX_ready, mX_rdata           : master X completion pulse and read data
//   s_valid/instr/addr/wdata/wstrb  : request forwarded to the decoder
//   s_ready, s_rdata             : decoder completion and read data
//   grant                        : one-hot current owner, 2'b00 when idle
//   timeout_error                : one-cycle pulse on forced termination
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_error
);

    // Parameter sanity: the counter must be able to reach TIMEOUT_CYCLES.
    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > ((2 ** CNT_WIDTH) - 1)) begin : g_param_check
            $error("mem_bus_arbiter: TIMEOUT_CYCLES must be >= 2 and fit in CNT_WIDTH bits");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 last_q, last_d;     // 1 = master 1 was granted last

    // Owner's request, zero when idle.
    logic        own_valid;
    logic        own_instr;
    logic [31:0] own_addr;
    logic [31:0] own_wdata;
    logic [3:0]  own_wstrb;

    logic busy;
    logic expired;
    logic done_ok;
    logic timeout_hit;
    logic finish;

    always_comb begin
        own_valid = 1'b0;
        own_instr = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        own_wstrb = '0;
        case (state_q)
            BUSY0: begin
                own_valid = m0_valid;
                own_instr = m0_instr;
                own_addr  = m0_addr;
                own_wdata = m0_wdata;
                own_wstrb = m0_wstrb;
            end
            BUSY1: begin
                own_valid = m1_valid;
                own_instr = m1_instr;
                own_addr  = m1_addr;
                own_wdata = m1_wdata;
                own_wstrb = m1_wstrb;
            end
            default: begin
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign expired     = busy && (cnt_q == TIMEOUT_VAL);
    assign done_ok     = own_valid && s_ready;
    // A decoder answer on the expiry cycle takes precedence over the watchdog.
    assign timeout_hit = expired && own_valid && !s_ready;
    assign finish      = done_ok || timeout_hit;

    // On forced termination the request is withdrawn from the decoder so it
    // cannot act on an access the master already considers finished.
    assign s_valid = own_valid && !timeout_hit;
    assign s_instr = own_instr;
    assign s_addr  = own_addr;
    assign s_wdata = own_wdata;
    assign s_wstrb = own_wstrb;

    assign m0_ready = (state_q == BUSY0) && finish;
    assign m1_ready = (state_q == BUSY1) && finish;
    assign m0_rdata = ((state_q == BUSY0) && done_ok) ? s_rdata : 32'h0;
    assign m1_rdata = ((state_q == BUSY1) && done_ok) ? s_rdata : 32'h0;

    assign grant         = {state_q == BUSY1, state_q == BUSY0};
    assign timeout_error = timeout_hit;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_valid && m1_valid) begin
                    // Tie: the master that did not win last time.
                    if (last_q) begin
                        state_d = BUSY0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = BUSY1;
                        last_d  = 1'b1;
                    end
                end else if (m0_valid) begin
                    state_d = BUSY0;
                    last_d  = 1'b0;
                end else if (m1_valid) begin
                    state_d = BUSY1;
                    last_d  = 1'b1;
                end
            end
            BUSY0, BUSY1: begin
                // Owner withdrawing valid abandons the access silently.
                if (!own_valid || finish) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != TIMEOUT_VAL) begin
                    cnt_d = cnt_q + 1'b1;   // saturates at TIMEOUT_VAL
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int T  = 8;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_error;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_error(timeout_error)
    );

    // One access: request fields plus how the decoder will answer it.
    // lat = busy cycle (0 = first cycle s_valid is seen) on which s_ready is given.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  wstrb;
        logic        instr;
        int          lat;
    } txn_t;

    txn_t       pend [2][$];   // not yet issued
    txn_t       exp_q[2][$];   // issued, awaiting completion
    txn_t       cur  [2];
    bit         active[2];
    logic [1:0] rdy_seen;
    int         gap_pct = 0;
    bit         spur_en = 0;
    int         dec_k   = 0;
    logic [1:0] dec_prev = 2'b00;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                                logic [3:0] wstrb, logic instr, int lat);
        txn_t t;
        t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.wstrb = wstrb; t.instr = instr; t.lat = lat;
        return t;
    endfunction

    // One clock of master and decoder behaviour, driven on the falling edge.
    task automatic step();
        int o;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            if (active[m] && rdy_seen[m]) active[m] = 0;
            if (!active[m] && pend[m].size() > 0 && ($urandom_range(0, 99) >= gap_pct)) begin
                cur[m]    = pend[m].pop_front();
                active[m] = 1;
                exp_q[m].push_back(cur[m]);
                $display("issue m%0d addr=%h wstrb=%h lat=%0d", m, cur[m].addr, cur[m].wstrb, cur[m].lat);
            end
        end
        m0_valid = active[0]; m0_instr = cur[0].instr; m0_addr = cur[0].addr;
        m0_wdata = cur[0].wdata; m0_wstrb = cur[0].wstrb;
        m1_valid = active[1]; m1_instr = cur[1].instr; m1_addr = cur[1].addr;
        m1_wdata = cur[1].wdata; m1_wstrb = cur[1].wstrb;
        if (grant != 2'b00) begin
            o = grant[1] ? 1 : 0;
            if (grant != dec_prev) dec_k = 0;
            else dec_k++;
            s_ready = (dec_k == cur[o].lat);
            s_rdata = s_ready ? cur[o].rdata : $urandom();
        end else begin
            s_ready = spur_en && ($urandom_range(0, 3) == 0);
            s_rdata = $urandom();
        end
        dec_prev = grant;
        #1;
        rdy_seen = {m1_ready, m0_ready};
    endtask

    task automatic run_until_done(string name, int max_cycles);
        int n;
        n = 0;
        while ((pend[0].size() + pend[1].size() > 0 || active[0] || active[1]) && n < max_cycles) begin
            step();
            n++;
        end
        chk({name, " finished in budget"}, 32'(n < max_cycles), 1);
        chk({name, " m0 drained"}, exp_q[0].size(), 0);
        chk({name, " m1 drained"}, exp_q[1].size(), 0);
    endtask

    task automatic wait_grant(string name, logic [1:0] g, int max_cycles);
        int n;
        n = 0;
        while (grant !== g && n < max_cycles) begin
            step();
            n++;
        end
        chk(name, grant, g);
    endtask

    task automatic check_reset_outputs(string name);
        chk({name, " ctrl"}, {s_valid, s_instr, s_wstrb, grant, m0_ready, m1_ready, timeout_error}, 0);
        chk({name, " s_addr"}, s_addr, 0);
        chk({name, " s_wdata"}, s_wdata, 0);
        chk({name, " m_rdata"}, m0_rdata | m1_rdata, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [1:0] mon_prev_grant = 2'b00;
    logic [1:0] mon_prev_v     = 2'b00;
    bit         mon_last       = 1;       // 1 = master 1 served last
    int         mon_k          = 0;
    logic [1:0] exp_g;
    logic [1:0] grant_log[$];
    txn_t       e;
    bit         e_err;
    logic       rdy;
    logic [31:0] rd;

    always begin
        @(negedge clk);
        #2;
        if (!reset_n) begin
            mon_last = 1; mon_k = 0; mon_prev_grant = 2'b00; mon_prev_v = 2'b00;
        end else begin
            chk("grant at most one owner", 32'($countones(grant) <= 1), 1);
            if (grant != 2'b00 && mon_prev_grant == 2'b00) begin
                case (mon_prev_v)
                    2'b01:   exp_g = 2'b01;
                    2'b10:   exp_g = 2'b10;
                    2'b11:   exp_g = mon_last ? 2'b01 : 2'b10;
                    default: exp_g = 2'b00;
                endcase
                chk("arbitration winner", grant, exp_g);
                mon_last = (exp_g == 2'b10);
                grant_log.push_back(grant);
                mon_k = 0;
            end else if (grant != 2'b00) begin
                chk("grant held while busy", grant, mon_prev_grant);
                mon_k++;
            end
            if (grant != 2'b00 && s_valid) begin
                chk("s_addr forwarded", s_addr, grant[1] ? m1_addr : m0_addr);
                chk("s_wdata forwarded", s_wdata, grant[1] ? m1_wdata : m0_wdata);
            end
            for (int m = 0; m < 2; m++) begin
                rdy = (m == 1) ? m1_ready : m0_ready;
                rd  = (m == 1) ? m1_rdata : m0_rdata;
                if (rdy) begin
                    chk($sformatf("m%0d ready only as owner", m), 32'(grant[m]), 1);
                    chk($sformatf("m%0d ready has outstanding access", m), 32'(exp_q[m].size() > 0), 1);
                    if (exp_q[m].size() > 0) begin
                        e = exp_q[m].pop_front();
                        e_err = (e.lat > T);
                        chk($sformatf("m%0d rdata", m), rd, e_err ? 32'h0 : e.rdata);
                        chk($sformatf("m%0d timeout_error", m), 32'(timeout_error), 32'(e_err));
                        chk($sformatf("m%0d completion cycle", m), mon_k, e_err ? T : e.lat);
                        $display("done  m%0d addr=%h rdata=%h err=%0d cycle=%0d", m, e.addr, rd, timeout_error, mon_k);
                    end
                end
            end
            if (timeout_error) begin
                chk("s_valid low on timeout", 32'(s_valid), 0);
                chk("timeout comes with ready", 32'(m0_ready | m1_ready), 1);
            end
            mon_prev_grant = grant;
            mon_prev_v     = {m1_valid, m0_valid};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 0;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0; rdy_seen = 0;
        for (int m = 0; m < 2; m++) begin
            cur[m] = mk(0, 0, 0, 0, 0, 0);
            active[m] = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset state");
        @(negedge clk);
        reset_n = 1;

        // Both masters requesting continuously from reset: m0, m1, m0, m1.
        grant_log.delete();
        pend[0].push_back(mk(32'h0000_0100, 0, 32'hA000_0001, 4'h0, 1'b1, 1));
        pend[0].push_back(mk(32'h0000_0104, 0, 32'hA000_0002, 4'h0, 1'b0, 3));
        pend[1].push_back(mk(32'h0200_0000, 32'h1111_2222, 32'hB000_0001, 4'h3, 1'b0, 2));
        pend[1].push_back(mk(32'h0200_0004, 0, 32'hB000_0002, 4'h0, 1'b0, 1));
        run_until_done("rr", 200);
        chk("rr grant count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            chk("rr order 0", grant_log[0], 2'b01);
            chk("rr order 1", grant_log[1], 2'b10);
            chk("rr order 2", grant_log[2], 2'b01);
            chk("rr order 3", grant_log[3], 2'b10);
        end

        // Single m0 read, decoder answers two cycles after s_valid.
        pend[0].push_back(mk(32'h0000_1000, 0, 32'h1234_5678, 4'h0, 1'b1, 2));
        run_until_done("m0 read", 50);

        // m1 write nobody answers: watchdog termination.
        pend[1].push_back(mk(32'hC300_0000, $urandom(), 32'hDEAD_BEEF, 4'hF, 1'b0, T + 5));
        run_until_done("timeout", 60);

        // Decoder answer exactly on the expiry cycle wins.
        pend[0].push_back(mk(32'h0000_2000, 0, 32'h5A5A_A5A5, 4'h0, 1'b0, T));
        run_until_done("expiry race", 60);

        // Reset for one cycle in the middle of a BUSY0 access.
        pend[0].push_back(mk(32'h0000_3000, 0, 32'h0, 4'h0, 1'b0, 1000));
        wait_grant("reset test grant m0", 2'b01, 20);
        step();
        reset_n = 0;
        active[0] = 0; active[1] = 0;
        pend[0].delete(); pend[1].delete();
        exp_q[0].delete(); exp_q[1].delete();
        m0_valid = 0; m1_valid = 0; s_ready = 0; rdy_seen = 0;
        @(negedge clk);
        reset_n = 1;
        #1;
        check_reset_outputs("after mid-access reset");
        grant_log.delete();
        pend[0].push_back(mk(32'h0000_4000, 0, 32'h0C0C_0C0C, 4'h0, 1'b0, 2));
        pend[1].push_back(mk(32'h0200_4000, 0, 32'h1D1D_1D1D, 4'h0, 1'b0, 2));
        run_until_done("post reset", 100);
        chk("post reset first grant", grant_log.size() > 0 ? grant_log[0] : 2'b00, 2'b01);

        // m0 withdraws valid while owning the bus; pending m1 follows.
        pend[0].push_back(mk(32'h0000_5000, 0, 32'h0, 4'h0, 1'b0, 1000));
        pend[1].push_back(mk(32'h0200_5000, 0, 32'h7777_8888, 4'h0, 1'b0, 3));
        wait_grant("drop test grant m0", 2'b01, 20);
        active[0] = 0;
        exp_q[0].delete();
        step();
        chk("drop: no m0_ready", 32'(rdy_seen[0]), 0);
        step();
        chk("drop: idle after withdraw", grant, 2'b00);
        step();
        chk("drop: m1 granted next", grant, 2'b10);
        run_until_done("drop", 60);

        // Random traffic with idle gaps and stray s_ready while idle.
        gap_pct = 30;
        spur_en = 1;
        for (int i = 0; i < 25; i++) begin
            for (int m = 0; m < 2; m++) begin
                pend[m].push_back(mk($urandom(), $urandom(), $urandom(), 4'($urandom_range(0, 15)),
                                     1'($urandom_range(0, 1)), $urandom_range(1, T + 2)));
            end
        end
        run_until_done("random", 5000);
        spur_en = 0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
